// File: rtl/fpga_cmd_spi_tx_if.sv
// Request/status and SPI pin bundle for the ARM->FPGA command frame transmitter.
interface fpga_cmd_spi_tx_if;
  logic        start;
  logic [3:0]  cmd;
  logic [11:0] data;
  logic        busy;
  logic        done;
  logic        spck;
  logic        mosi;
  logic        ncs;

  modport master (output start, cmd, data, input busy, done, spck, mosi, ncs);
  modport slave  (input start, cmd, data, output busy, done, spck, mosi, ncs);
endinterface

// File: rtl/fpga_cmd_spi_tx.sv
// SPI-master transmitter for the 16-bit {cmd,data} config frame, MSB first.
// All outputs come straight from registers; the FSM computes their next values.
module fpga_cmd_spi_tx #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_MULT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fpga_cmd_spi_tx_if.slave     io_bus
);

  localparam logic [7:0] H_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] GAP_LAST = 5'(GAP_MULT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_half, w_half;
  logic [4:0]  r_bit, w_bit;
  logic [15:0] r_frame, w_frame;
  logic        r_spck, w_spck;
  logic        r_mosi, w_mosi;
  logic        r_ncs, w_ncs;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        w_last_half;
  logic [3:0]  w_idx;

  assign w_last_half = (r_half == H_LAST);
  assign w_idx       = 4'd14 - r_bit[3:0];

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_half  <= 8'd0;
      r_bit   <= 5'd0;
      r_frame <= 16'd0;
      r_spck  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_half  <= w_half;
      r_bit   <= w_bit;
      r_frame <= w_frame;
      r_spck  <= w_spck;
      r_mosi  <= w_mosi;
      r_ncs   <= w_ncs;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state = r_state;
    w_half  = r_half + 8'd1;
    w_bit   = r_bit;
    w_frame = r_frame;
    w_spck  = r_spck;
    w_mosi  = r_mosi;
    w_ncs   = r_ncs;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_half = 8'd0;
        w_bit  = 5'd0;
        w_busy = 1'b0;
        if (io_bus.start) begin
          w_frame = {io_bus.cmd, io_bus.data};
          w_state = S_SETUP;
          w_ncs   = 1'b0;
          w_busy  = 1'b1;
          w_mosi  = io_bus.cmd[3];
          w_spck  = 1'b0;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SETUP: begin
        if (w_last_half) begin
          w_state = S_SHIFT;
          w_half  = 8'd0;
          w_spck  = 1'b1;
        end else begin
          w_state = S_SETUP;
        end
      end
      S_SHIFT: begin
        // The low phase after the 16th fall is spent in HOLD, not here.
        if (w_last_half) begin
          w_half = 8'd0;
          if (r_spck) begin
            w_spck = 1'b0;
            if (r_bit == 5'd15) begin
              w_state = S_HOLD;
              w_bit   = 5'd0;
            end else begin
              w_bit  = r_bit + 5'd1;
              w_mosi = r_frame[w_idx];
            end
          end else begin
            w_spck = 1'b1;
          end
        end else begin
          w_state = S_SHIFT;
        end
      end
      S_HOLD: begin
        if (w_last_half) begin
          w_state = S_GAP;
          w_half  = 8'd0;
          w_ncs   = 1'b1;
          w_mosi  = 1'b0;
        end else begin
          w_state = S_HOLD;
        end
      end
      S_GAP: begin
        // Bit counter is reused here to count whole H units of the gap.
        if (w_last_half) begin
          w_half = 8'd0;
          if (r_bit == GAP_LAST) begin
            w_state = S_DONE;
            w_bit   = 5'd0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_bit = r_bit + 5'd1;
          end
        end else begin
          w_state = S_GAP;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_half  = 8'd0;
        w_bit   = 5'd0;
        w_spck  = 1'b0;
        w_mosi  = 1'b0;
        w_ncs   = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.spck = r_spck;
  assign io_bus.mosi = r_mosi;
  assign io_bus.ncs  = r_ncs;

endmodule

// File: tb/tb_fpga_cmd_spi_tx.sv
// Directed bench: a receiver model shifts mosi on rising spck under low ncs and
// latches on rising ncs; timing is measured relative to the acceptance edge.
module tb_fpga_cmd_spi_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpga_cmd_spi_tx_if b0 ();
  fpga_cmd_spi_tx_if b1 ();

  fpga_cmd_spi_tx #(.CLK_DIV(4), .GAP_MULT(2)) u_dut0 (.clk(clk), .rst(rst), .io_bus(b0));
  fpga_cmd_spi_tx #(.CLK_DIV(1), .GAP_MULT(2)) u_dut1 (.clk(clk), .rst(rst), .io_bus(b1));

  logic [1:0] m_ncs, m_spck, m_mosi, m_done, m_busy;
  assign m_ncs  = {b1.ncs,  b0.ncs};
  assign m_spck = {b1.spck, b0.spck};
  assign m_mosi = {b1.mosi, b0.mosi};
  assign m_done = {b1.done, b0.done};
  assign m_busy = {b1.busy, b0.busy};

  logic [1:0]  p_ncs = 2'b11;
  logic [1:0]  p_spck = 2'b00;
  logic [15:0] shreg [2];
  logic [15:0] cap_frame [2][8];
  int cap_rises [2][8];
  int cap_n [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int fall_cyc [2] = '{0, 0};
  int rise_cyc [2] = '{0, 0};
  int first_rise [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  bit have_first [2] = '{1'b0, 1'b0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int busy_cnt [2] = '{0, 0};
  int gap_cnt [2] = '{0, 0};
  int viol [2] = '{0, 0};
  int mosi0 [2] = '{0, 0};

  // Receiver model and event recorder for both instances
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d]) busy_cnt[d]++;
      if (m_done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (m_ncs[d] && m_busy[d]) gap_cnt[d]++;
      if (!m_ncs[d] && !m_mosi[d]) mosi0[d]++;
      if ((m_spck[d] != p_spck[d]) && (m_ncs[d] || (m_ncs[d] != p_ncs[d]))) viol[d]++;
      if (p_ncs[d] && !m_ncs[d]) begin
        fall_cyc[d] = cyc;
        rises[d] = 0;
        shreg[d] = 16'd0;
        have_first[d] = 1'b0;
      end else if (!p_ncs[d] && m_ncs[d]) begin
        rise_cyc[d] = cyc;
        if (cap_n[d] < 8) begin
          cap_frame[d][cap_n[d]] = shreg[d];
          cap_rises[d][cap_n[d]] = rises[d];
        end
        cap_n[d]++;
      end else if (!m_ncs[d] && m_spck[d] && !p_spck[d]) begin
        shreg[d] = {shreg[d][14:0], m_mosi[d]};
        rises[d]++;
        last_rise[d] = cyc;
        if (!have_first[d]) begin
          first_rise[d] = cyc;
          have_first[d] = 1'b1;
        end
      end
      p_ncs[d] = m_ncs[d];
      p_spck[d] = m_spck[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int prev, input int budget);
    int n;
    n = 0;
    while (done_cnt[d] == prev && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", 32'(done_cnt[d] - prev), 32'd1);
  endtask

  int e0, e1, d_prev, b_prev, g_prev, m_prev, rd, done1, n;

  initial begin
    b0.start = 1'b0; b0.cmd = 4'h0; b0.data = 12'h000;
    b1.start = 1'b0; b1.cmd = 4'h0; b1.data = 12'h000;
    repeat (3) step();
    chk("rst_ncs",  32'(b0.ncs),  32'd1);
    chk("rst_spck", 32'(b0.spck), 32'd0);
    chk("rst_mosi", 32'(b0.mosi), 32'd0);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_done", 32'(b0.done), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Frame 10C1 with late data change and a start pulse while busy
    d_prev = done_cnt[0]; b_prev = busy_cnt[0]; g_prev = gap_cnt[0]; rd = cap_n[0];
    b0.start = 1'b1; b0.cmd = 4'h1; b0.data = 12'h0C1; e0 = cyc + 1;
    step();
    b0.start = 1'b0; b0.cmd = 4'h0; b0.data = 12'hFFF;
    n = 0;
    while (cyc - e0 != 49 && n < 200) begin step(); n++; end
    b0.start = 1'b1; b0.cmd = 4'hF;
    step();
    b0.start = 1'b0;
    wait_done(0, d_prev, 400);
    repeat (20) step();
    chk("a_ncs_fall",   32'(fall_cyc[0] - e0),   32'd0);
    chk("a_first_rise", 32'(first_rise[0] - e0), 32'd4);
    chk("a_ncs_rise",   32'(rise_cyc[0] - e0),   32'd132);
    chk("a_done_at",    32'(done_cyc[0] - e0),   32'd140);
    chk("a_done_cnt",   32'(done_cnt[0] - d_prev), 32'd1);
    chk("a_busy_len",   32'(busy_cnt[0] - b_prev), 32'd140);
    chk("a_gap_len",    32'(gap_cnt[0] - g_prev),  32'd8);
    chk("a_frames",     32'(cap_n[0] - rd),      32'd1);
    chk("a_frame",      32'(cap_frame[0][rd]),   32'h10C1);
    chk("a_rises",      32'(cap_rises[0][rd]),   32'd16);
    chk("a_viol",       32'(viol[0]),            32'd0);

    // Back-to-back 2080 then 30FF with start held high
    d_prev = done_cnt[0]; g_prev = gap_cnt[0]; rd = cap_n[0];
    b0.start = 1'b1; b0.cmd = 4'h2; b0.data = 12'h080;
    wait_done(0, d_prev, 400);
    done1 = done_cyc[0];
    chk("bb_gap_len", 32'(gap_cnt[0] - g_prev), 32'd8);
    b0.cmd = 4'h3; b0.data = 12'h0FF; e1 = cyc + 1;
    step();
    b0.start = 1'b0;
    wait_done(0, d_prev + 1, 400);
    chk("bb_fall2",   32'(fall_cyc[0] - done1), 32'd1);
    chk("bb_fall2_e", 32'(fall_cyc[0] - e1),    32'd0);
    chk("bb_frames",  32'(cap_n[0] - rd),       32'd2);
    chk("bb_frame1",  32'(cap_frame[0][rd]),    32'h2080);
    chk("bb_frame2",  32'(cap_frame[0][rd + 1]), 32'h30FF);
    chk("bb_rises1",  32'(cap_rises[0][rd]),    32'd16);
    chk("bb_rises2",  32'(cap_rises[0][rd + 1]), 32'd16);
    chk("bb_viol",    32'(viol[0]),             32'd0);
    repeat (4) step();

    // Async reset mid-frame, then resend A5A5
    b0.start = 1'b1; b0.cmd = 4'h1; b0.data = 12'h0C1; e0 = cyc + 1;
    step();
    b0.start = 1'b0;
    n = 0;
    while (cyc - e0 != 59 && n < 200) begin step(); n++; end
    chk("r_pre_ncs", 32'(b0.ncs), 32'd0);
    rst = 1'b1;
    #1;
    chk("r_ncs",  32'(b0.ncs),  32'd1);
    chk("r_spck", 32'(b0.spck), 32'd0);
    chk("r_mosi", 32'(b0.mosi), 32'd0);
    chk("r_busy", 32'(b0.busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    d_prev = done_cnt[0]; rd = cap_n[0];
    b0.start = 1'b1; b0.cmd = 4'hA; b0.data = 12'h5A5;
    step();
    b0.start = 1'b0;
    wait_done(0, d_prev, 400);
    chk("r_frame", 32'(cap_frame[0][rd]), 32'hA5A5);
    chk("r_rises", 32'(cap_rises[0][rd]), 32'd16);

    // CLK_DIV=1 instance with an all-ones frame
    d_prev = done_cnt[1]; b_prev = busy_cnt[1]; m_prev = mosi0[1]; rd = cap_n[1];
    b1.start = 1'b1; b1.cmd = 4'hF; b1.data = 12'hFFF; e0 = cyc + 1;
    step();
    b1.start = 1'b0;
    wait_done(1, d_prev, 200);
    chk("d1_ncs_fall",   32'(fall_cyc[1] - e0),   32'd0);
    chk("d1_first_rise", 32'(first_rise[1] - e0), 32'd1);
    chk("d1_rise_span",  32'(last_rise[1] - first_rise[1]), 32'd30);
    chk("d1_ncs_rise",   32'(rise_cyc[1] - e0),   32'd33);
    chk("d1_done_at",    32'(done_cyc[1] - e0),   32'd35);
    chk("d1_busy_len",   32'(busy_cnt[1] - b_prev), 32'd35);
    chk("d1_mosi_low",   32'(mosi0[1] - m_prev),  32'd0);
    chk("d1_frame",      32'(cap_frame[1][rd]),   32'hFFFF);
    chk("d1_rises",      32'(cap_rises[1][rd]),   32'd16);
    chk("d1_viol",       32'(viol[1]),            32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
